// File: rtl/echo_request_input.sv
// Request-direction demarshaller for the echo portal: parses header words, gathers
// arguments and fires one say/say2 call per well-formed message. Optional error counter via ECHO_REQ_ERRCNT_EN.
module echo_request_input (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] requests_0_enq_v,
    input  logic        EN_requests_0_enq,
    output logic        RDY_requests_0_enq,
    input  logic [15:0] messageSize_size_methodNumber,
    output logic [15:0] messageSize_size,
    output logic [31:0] say_v,
    output logic        EN_say,
    input  logic        RDY_say,
    output logic [15:0] say2_a,
    output logic [15:0] say2_b,
    output logic        EN_say2,
    input  logic        RDY_say2
`ifdef ECHO_REQ_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [1:0] {HDR, ARGS, ISSUE, DISCARD} stateT;

    stateT       state;
    logic [15:0] method;
    logic [15:0] remaining;
    logic        argSlot;
    logic [31:0] sayV;
    logic [15:0] say2A;
    logic [15:0] say2B;

    logic        accept;
    logic [15:0] hdrMethod;
    logic [15:0] hdrLen;
    logic [15:0] hdrRemaining;
    logic        hdrWellFormed;
    logic        fire;

    // A zero length field counts as a bare header, so both 0 and 1 leave nothing to consume.
    always_comb begin
        hdrMethod     = requests_0_enq_v[31:16];
        hdrLen        = requests_0_enq_v[15:0];
        hdrRemaining  = (hdrLen == 16'd0) ? 16'd0 : hdrLen - 16'd1;
        hdrWellFormed = ((hdrMethod == 16'd0) && (hdrLen == 16'd2)) ||
                        ((hdrMethod == 16'd1) && (hdrLen == 16'd3));
    end

    assign RDY_requests_0_enq = (state != ISSUE);
    assign accept   = EN_requests_0_enq && RDY_requests_0_enq;
    assign EN_say   = (state == ISSUE) && (method == 16'd0) && RDY_say;
    assign EN_say2  = (state == ISSUE) && (method == 16'd1) && RDY_say2;
    assign fire     = EN_say || EN_say2;
    assign say_v    = sayV;
    assign say2_a   = say2A;
    assign say2_b   = say2B;

    assign messageSize_size = ((messageSize_size_methodNumber == 16'd0) ||
                               (messageSize_size_methodNumber == 16'd1)) ? 16'd32 : 16'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= HDR;
            method    <= 16'd0;
            remaining <= 16'd0;
            argSlot   <= 1'b0;
            sayV      <= 32'd0;
            say2A     <= 16'd0;
            say2B     <= 16'd0;
        end else begin
            case (state)
                HDR: begin
                    if (accept) begin
                        method    <= hdrMethod;
                        remaining <= hdrRemaining;
                        argSlot   <= 1'b0;
                        if (hdrWellFormed)
                            state <= ARGS;
                        else if (hdrRemaining != 16'd0)
                            state <= DISCARD;
                    end
                end
                ARGS: begin
                    if (accept) begin
                        if (method == 16'd0)
                            sayV <= requests_0_enq_v;
                        else if (!argSlot)
                            say2A <= requests_0_enq_v[15:0];
                        else
                            say2B <= requests_0_enq_v[15:0];
                        argSlot   <= 1'b1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fire)
                        state <= HDR;
                end
                DISCARD: begin
                    if (accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

`ifdef ECHO_REQ_ERRCNT_EN
    // Saturating count of malformed headers; only reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_count <= 8'd0;
        else if ((state == HDR) && accept && !hdrWellFormed && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_echo_request_input.sv
// Bench for echo_request_input: directed test-plan scenarios plus randomized message
// streams checked each cycle against a message-level reference model.
module tb_echo_request_input;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] requests_0_enq_v = 32'd0;
    logic        EN_requests_0_enq = 1'b0;
    logic        RDY_requests_0_enq;
    logic [15:0] messageSize_size_methodNumber = 16'd0;
    logic [15:0] messageSize_size;
    logic [31:0] say_v;
    logic        EN_say;
    logic        RDY_say = 1'b0;
    logic [15:0] say2_a;
    logic [15:0] say2_b;
    logic        EN_say2;
    logic        RDY_say2 = 1'b0;
`ifdef ECHO_REQ_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    echo_request_input dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .requests_0_enq_v              (requests_0_enq_v),
        .EN_requests_0_enq             (EN_requests_0_enq),
        .RDY_requests_0_enq            (RDY_requests_0_enq),
        .messageSize_size_methodNumber (messageSize_size_methodNumber),
        .messageSize_size              (messageSize_size),
        .say_v                         (say_v),
        .EN_say                        (EN_say),
        .RDY_say                       (RDY_say),
        .say2_a                        (say2_a),
        .say2_b                        (say2_b),
        .EN_say2                       (EN_say2),
        .RDY_say2                      (RDY_say2)
`ifdef ECHO_REQ_ERRCNT_EN
        ,
        .err_count                     (err_count)
`endif
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;

    // Message-level model: a message in flight, and at most one call waiting for the core.
    logic        inMsg = 1'b0;
    logic        msgGood = 1'b0;
    logic [15:0] msgMethod = 16'd0;
    int          wordsLeft = 0;
    int          nArgs = 0;
    logic [31:0] args [2];
    logic        pend = 1'b0;
    logic [15:0] pendMethod = 16'd0;
    logic [31:0] pendA = 32'd0;
    logic [31:0] pendB = 32'd0;
    int          errCnt = 0;

    logic        obsRdy, obsEnSay, obsEnSay2, lastAccepted;
    logic [31:0] obsSayV;
    logic [15:0] obsSay2A, obsSay2B, obsSize;
    logic [7:0]  obsErr;

    logic [31:0] wordQ [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        inMsg = 1'b0; msgGood = 1'b0; wordsLeft = 0; nArgs = 0;
        pend = 1'b0; errCnt = 0;
    endtask

    task automatic modelFeed(input logic [31:0] w);
        int len;
        if (!inMsg) begin
            len = int'(w[15:0]);
            if (len == 0) len = 1;
            msgGood   = ((w[31:16] == 16'd0) && (w[15:0] == 16'd2)) ||
                        ((w[31:16] == 16'd1) && (w[15:0] == 16'd3));
            if (!msgGood && errCnt < 255) errCnt++;
            msgMethod = w[31:16];
            wordsLeft = len - 1;
            nArgs     = 0;
            inMsg     = (wordsLeft > 0);
        end else begin
            if (nArgs < 2) args[nArgs] = w;
            nArgs++;
            wordsLeft--;
            if (wordsLeft == 0) begin
                inMsg = 1'b0;
                if (msgGood) begin
                    pend = 1'b1; pendMethod = msgMethod;
                    pendA = args[0]; pendB = args[1];
                end
            end
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, account for the edge.
    task automatic applyStimulus(input logic enq, input logic [31:0] w, input logic rs,
                                 input logic rs2, input logic [15:0] qnum);
        logic expRdy, expSay, expSay2;
        @(negedge CLK);
        EN_requests_0_enq = enq;
        requests_0_enq_v  = w;
        RDY_say  = rs;
        RDY_say2 = rs2;
        messageSize_size_methodNumber = qnum;
        #1;
        expRdy  = !pend;
        expSay  = pend && (pendMethod == 16'd0) && rs;
        expSay2 = pend && (pendMethod == 16'd1) && rs2;
        checkOutput("RDY_requests_0_enq", {31'd0, RDY_requests_0_enq}, {31'd0, expRdy});
        checkOutput("EN_say", {31'd0, EN_say}, {31'd0, expSay});
        checkOutput("EN_say2", {31'd0, EN_say2}, {31'd0, expSay2});
        if (expSay && EN_say) checkOutput("say_v", say_v, pendA);
        if (expSay2 && EN_say2) begin
            checkOutput("say2_a", {16'd0, say2_a}, {16'd0, pendA[15:0]});
            checkOutput("say2_b", {16'd0, say2_b}, {16'd0, pendB[15:0]});
        end
        checkOutput("messageSize_size", {16'd0, messageSize_size},
                    (qnum == 16'd0 || qnum == 16'd1) ? 32'd32 : 32'd0);
        obsErr = 8'd0;
`ifdef ECHO_REQ_ERRCNT_EN
        checkOutput("err_count", {24'd0, err_count}, errCnt);
        obsErr = err_count;
`endif
        obsRdy = RDY_requests_0_enq; obsEnSay = EN_say; obsEnSay2 = EN_say2;
        obsSayV = say_v; obsSay2A = say2_a; obsSay2B = say2_b; obsSize = messageSize_size;
        lastAccepted = enq && expRdy;
        if (expSay || expSay2) pend = 1'b0;
        @(posedge CLK);
        if (lastAccepted) modelFeed(w);
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RST = 1'b1;
        EN_requests_0_enq = 1'b0;
        #1;
        modelReset();
        checkOutput("reset RDY_requests_0_enq", {31'd0, RDY_requests_0_enq}, 32'd1);
        checkOutput("reset EN_say", {31'd0, EN_say}, 32'd0);
        checkOutput("reset EN_say2", {31'd0, EN_say2}, 32'd0);
        checkOutput("reset say_v", say_v, 32'd0);
        checkOutput("reset say2_a/b", {say2_a, say2_b}, 32'd0);
`ifdef ECHO_REQ_ERRCNT_EN
        checkOutput("reset err_count", {24'd0, err_count}, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Hands a word to the pipe once the model says the block can take it, bounded wait.
    task automatic sendWord(input logic [31:0] w);
        for (int t = 0; t < 50; t++) begin
            if (!pend) begin
                applyStimulus(1'b1, w, 1'b1, 1'b1, 16'd0);
                return;
            end
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 16'd0);
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL sendWord timeout: word 0x%08h never accepted, want accepted", w);
    endtask

    task automatic queueRandomMessage();
        int kind, len;
        logic [15:0] m;
        kind = $urandom_range(0, 5);
        case (kind)
            0: begin m = 16'd0; len = 2; end
            1: begin m = 16'd1; len = 3; end
            2: begin m = 16'($urandom_range(2, 65535)); len = $urandom_range(0, 6); end
            3: begin
                m = 16'($urandom_range(0, 1));
                len = $urandom_range(0, 5);
                if ((m == 16'd0 && len == 2) || (m == 16'd1 && len == 3)) len = 4;
            end
            4: begin m = 16'($urandom_range(0, 9)); len = $urandom_range(7, 40);
                if (m <= 16'd1) m = 16'd9; end
            default: begin m = 16'd0; len = 2; end
        endcase
        wordQ.push_back({m, 16'(len)});
        for (int i = 1; i < len; i++) wordQ.push_back($urandom);
    endtask

    initial begin
        $display("[TB] start");
        applyReset();

        // say with 0xDEADBEEF
        sendWord(32'h0000_0002);
        sendWord(32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 16'd0);
        checkOutput("t1 EN_say", {31'd0, obsEnSay}, 32'd1);
        checkOutput("t1 say_v", obsSayV, 32'hDEAD_BEEF);
        checkOutput("t1 RDY low", {31'd0, obsRdy}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 16'd0);
        checkOutput("t1 RDY back", {31'd0, obsRdy}, 32'd1);

        // say2 held off by the core; stray writes during the stall are ignored
        sendWord(32'h0001_0003);
        sendWord(32'h1234_5678);
        sendWord(32'hFFFF_9ABC);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'(i % 2), 32'hCAFE_0000 + i, 1'b1, 1'b0, 16'd0);
            checkOutput("t2 stalled EN_say2", {31'd0, obsEnSay2}, 32'd0);
            checkOutput("t2 stalled RDY", {31'd0, obsRdy}, 32'd0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 16'd0);
        checkOutput("t2 EN_say2", {31'd0, obsEnSay2}, 32'd1);
        checkOutput("t2 say2_a", {16'd0, obsSay2A}, 32'h5678);
        checkOutput("t2 say2_b", {16'd0, obsSay2B}, 32'h9ABC);

        // unknown method with 3 payload words, then a valid say
        applyReset();
        sendWord(32'h0007_0004);
        for (int i = 0; i < 3; i++) sendWord($urandom);
        sendWord(32'h0000_0002);
        sendWord(32'h0000_0001);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 16'd0);
        checkOutput("t3 EN_say", {31'd0, obsEnSay}, 32'd1);
        checkOutput("t3 say_v", obsSayV, 32'h0000_0001);
`ifdef ECHO_REQ_ERRCNT_EN
        checkOutput("t3 err_count", {24'd0, obsErr}, 32'd1);
`endif

        // bare wrong-length headers, saturating the error count
        applyReset();
        sendWord(32'h0000_0001);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 16'd0);
        checkOutput("t4 RDY", {31'd0, obsRdy}, 32'd1);
`ifdef ECHO_REQ_ERRCNT_EN
        checkOutput("t4 err_count one", {24'd0, obsErr}, 32'd1);
`endif
        for (int i = 0; i < 255; i++) sendWord(32'h0000_0001);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 16'd0);
`ifdef ECHO_REQ_ERRCNT_EN
        checkOutput("t4 err_count saturated", {24'd0, obsErr}, 32'd255);
`endif

        // messageSize queries
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 16'd0);
        checkOutput("size m0", {16'd0, obsSize}, 32'd32);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 16'd1);
        checkOutput("size m1", {16'd0, obsSize}, 32'd32);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 16'd2);
        checkOutput("size m2", {16'd0, obsSize}, 32'd0);

        // long discard of 1023 payload words, then a valid say
        sendWord(32'h1234_0400);
        for (int i = 0; i < 1023; i++) sendWord($urandom);
        sendWord(32'h0000_0002);
        sendWord(32'h0BAD_F00D);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 16'd0);
        checkOutput("long discard EN_say", {31'd0, obsEnSay}, 32'd1);
        checkOutput("long discard say_v", obsSayV, 32'h0BAD_F00D);

        // reset while a say2 header is in flight
        sendWord(32'h0001_0003);
        applyReset();
        sendWord(32'h0000_0002);
        sendWord(32'hA5A5_A5A5);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 16'd0);
        checkOutput("t6 EN_say", {31'd0, obsEnSay}, 32'd1);
        checkOutput("t6 say_v", obsSayV, 32'hA5A5_A5A5);
`ifdef ECHO_REQ_ERRCNT_EN
        checkOutput("t6 err_count", {24'd0, obsErr}, 32'd0);
`endif

        // randomized message stream
        for (int c = 0; c < 4000; c++) begin
            logic enq;
            logic [31:0] w;
            if ($urandom_range(0, 499) == 0) begin
                applyReset();
                wordQ.delete();
            end
            if (wordQ.size() == 0) queueRandomMessage();
            if (pend) begin
                enq = 1'($urandom_range(0, 1));
                w   = $urandom;
            end else begin
                enq = ($urandom_range(0, 3) != 0);
                w   = wordQ[0];
            end
            applyStimulus(enq, w, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                          16'($urandom_range(0, 3)));
            if (lastAccepted) void'(wordQ.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/echo_request_input.md
# echo_request_input

Request-direction demarshaller for the echo portal: accepts 32-bit words written by software into the portal request pipe, parses a header word, assembles method arguments and fires exactly one method call per well-formed message into the echo core. It is the inbound counterpart of the indication marshaller. It sits between the portal request pipe and the core's `say`/`say2` method ports, and applies backpressure to the pipe while a decoded call waits for the core.

## Interface
- No parameters; word width 32, method-number width 16.
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- requests_0_enq_v  in  32  request word from portal.
- EN_requests_0_enq  in  1  word-transfer strobe; legal only while RDY_requests_0_enq=1.
- RDY_requests_0_enq  out  1  block can accept a word this cycle.
- messageSize_size_methodNumber  in  16  method number queried.
- messageSize_size  out  16  argument payload bits for queried method (combinational).
- say_v  out  32  argument of `say`.
- EN_say  out  1  `say` fires this cycle.
- RDY_say  in  1  core can accept `say`.
- say2_a, say2_b  out  16 each  arguments of `say2`.
- EN_say2  out  1  `say2` fires this cycle.
- RDY_say2  in  1  core can accept `say2`.
- err_count  out  8  malformed-message count (only with ECHO_REQ_ERRCNT_EN).

## Operation
- Header word: bits[31:16] method number, bits[15:0] message length in words including header; length 0 is treated as 1.
- Method 0 `say`: length must be 2; word1 -> say_v.
- Method 1 `say2`: length must be 3; word1[15:0] -> say2_a, word2[15:0] -> say2_b; upper 16 bits ignored.
- messageSize_size: 32 for method 0, 32 for method 1, 0 for any other number.
- States: HDR, ARGS, ISSUE, DISCARD.
- HDR: on accepted word, latch method and length; remaining = length-1. Known method with correct length -> ARGS. Otherwise malformed: remaining=0 -> stay HDR; remaining>0 -> DISCARD. Malformed counts one error.
- ARGS: each accepted word stored into next argument slot; on last argument -> ISSUE.
- ISSUE: RDY_requests_0_enq=0. EN_say = (method==0) && RDY_say; EN_say2 = (method==1) && RDY_say2. Enable never asserted without matching RDY. Cycle the enable is high -> HDR.
- DISCARD: accept and drop words, decrement remaining; remaining reaches 0 -> HDR.
- RDY_requests_0_enq=1 in HDR, ARGS, DISCARD.
- Argument outputs hold last latched values outside ISSUE; only enables are meaningful.

## Timing
- Reset (async assert, sync effect on release): state HDR, RDY_requests_0_enq=1, EN_say=EN_say2=0, say_v=0, say2_a=say2_b=0, err_count=0.
- Reset mid-message: partial message dropped, no enable, no error counted.
- Last argument accepted in cycle N -> enable earliest in cycle N+1; if core RDY low, enable waits, arguments stable.
- Enable in cycle M -> next header accepted in cycle M+1; back-to-back `say` messages sustain one call per 3 cycles.
- Words with EN_requests_0_enq while RDY_requests_0_enq=0 are a protocol violation; ignored, no state change.
- Length field up to 65535 supported in DISCARD; remaining counter 16 bits, no wrap.

## Configuration
- ECHO_REQ_ERRCNT_EN defined: err_count port present; 8-bit counter increments once per malformed header, saturates at 255, cleared only by RST.
- Not defined: err_count port and counter absent; malformed messages still discarded identically.

## Test plan
- Header 0x0000_0002, word 0xDEAD_BEEF, RDY_say=1 -> EN_say one cycle after word 2, say_v=0xDEADBEEF, RDY_requests_0_enq low exactly that cycle.
- Header 0x0001_0003, words 0x1234_5678, 0xFFFF_9ABC, RDY_say2=0 for 5 cycles then 1 -> EN_say2 once after RDY rises, say2_a=0x5678, say2_b=0x9ABC; pipe stalled throughout.
- Header 0x0007_0004 plus 3 words, then valid `say` 0x0000_0001 -> 3 words dropped, no enables, err_count=1, then EN_say with say_v=1.
- Header 0x0000_0001 (wrong length, no payload) -> immediately back to HDR, err_count=1; 256 such headers -> err_count=255.
- Query messageSize_size_methodNumber=0,1,2 -> 32, 32, 0.
- Assert RST after header+0 args of `say2` -> outputs return to reset values; subsequent `say` 0xA5A5_A5A5 delivered normally, err_count=0.
